// File: rtl/params.sv
// rtl/params.sv - shared register-file types
package params;
    typedef logic [4:0]  reg_index;
    typedef logic [31:0] word;

    typedef enum logic [0:0] {
        IDLE_REG_OP    = 1'b0,
        WRITE_REG_DATA = 1'b1
    } reg_file_op_t;
endpackage

// File: rtl/wb_queue_if.sv
// rtl/wb_queue_if.sv - result handshakes and register-file write port of the writeback queue
interface wb_queue_if;
    logic                 alu_valid;
    logic                 alu_ready;
    params::reg_index     alu_rd;
    params::word          alu_data;
    logic                 lsu_valid;
    logic                 lsu_ready;
    params::reg_index     lsu_rd;
    params::word          lsu_data;
    params::reg_file_op_t mem_op;
    params::reg_index     rd;
    params::word          write_data;

    modport master (
        output alu_valid, alu_rd, alu_data, lsu_valid, lsu_rd, lsu_data,
        input  alu_ready, lsu_ready, mem_op, rd, write_data
    );

    modport slave (
        input  alu_valid, alu_rd, alu_data, lsu_valid, lsu_rd, lsu_data,
        output alu_ready, lsu_ready, mem_op, rd, write_data
    );
endinterface

// File: rtl/wb_queue.sv
// rtl/wb_queue.sv - in-order writeback FIFO driving the register-file write port
// Optional WB_BYPASS_EN adds the lookup_idx/lookup_hit/lookup_data forwarding port.
module wb_queue
    import params::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clock,
    input  logic                   reset,
    wb_queue_if.slave              bus,
    input  logic                   flush,
    output logic [31:0]            pending,
    output logic [$clog2(DEPTH):0] count,
    output logic                   empty,
    output logic                   full
`ifdef WB_BYPASS_EN
    ,
    input  reg_index               lookup_idx,
    output logic                   lookup_hit,
    output word                    lookup_data
`endif
);

    localparam int AW = $clog2(DEPTH);

    reg_index          ent_rd   [DEPTH];
    word               ent_data [DEPTH];
    logic [DEPTH-1:0]  ent_valid;
    logic [AW-1:0]     head;
    logic [AW-1:0]     tail;
    logic [AW:0]       occ;

    logic     push_lsu;
    logic     push_alu;
    logic     push;
    logic     pop;
    reg_index push_rd;
    word      push_data;

    assign full  = (occ == (AW+1)'(DEPTH));
    assign empty = (occ == '0);
    assign count = occ;

    // Readies look only at registered occupancy, so a same-cycle pop never frees a slot.
    assign bus.lsu_ready = !reset && !full && !flush;
    assign bus.alu_ready = !reset && !full && !flush && !bus.lsu_valid;

    assign push_lsu  = bus.lsu_valid && bus.lsu_ready;
    assign push_alu  = bus.alu_valid && bus.alu_ready;
    assign push_rd   = push_lsu ? bus.lsu_rd   : bus.alu_rd;
    assign push_data = push_lsu ? bus.lsu_data : bus.alu_data;
    assign push      = (push_lsu || push_alu) && (push_rd != '0);
    assign pop       = !empty;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            head      <= '0;
            tail      <= '0;
            occ       <= '0;
            ent_valid <= '0;
        end else if (flush) begin
            head      <= '0;
            tail      <= '0;
            occ       <= '0;
            ent_valid <= '0;
        end else begin
            if (pop) begin
                ent_valid[head] <= 1'b0;
                head            <= head + 1'b1;
            end
            if (push) begin
                ent_valid[tail] <= 1'b1;
                tail            <= tail + 1'b1;
            end
            occ <= occ + (AW+1)'(push) - (AW+1)'(pop);
        end
    end

    // Payload needs no reset: it is only observed through ent_valid.
    always_ff @(posedge clock) begin
        if (push) begin
            ent_rd[tail]   <= push_rd;
            ent_data[tail] <= push_data;
        end
    end

    always_comb begin
        bus.mem_op     = IDLE_REG_OP;
        bus.rd         = '0;
        bus.write_data = '0;
        if (!empty) begin
            bus.rd         = ent_rd[head];
            bus.write_data = ent_data[head];
            if (!flush && !reset) begin
                bus.mem_op = WRITE_REG_DATA;
            end
        end
    end

    always_comb begin
        pending = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (ent_valid[i]) begin
                pending[ent_rd[i]] = 1'b1;
            end
        end
        pending[0] = 1'b0;
    end

`ifdef WB_BYPASS_EN
    // Walk oldest to youngest so the last match, the youngest value, wins.
    always_comb begin
        logic [AW-1:0] idx;
        idx         = '0;
        lookup_hit  = 1'b0;
        lookup_data = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = head + AW'(i);
            if (lookup_idx != '0 && ent_valid[idx] && ent_rd[idx] == lookup_idx) begin
                lookup_hit  = 1'b1;
                lookup_data = ent_data[idx];
            end
        end
    end
`endif

endmodule

// File: tb/tb_wb_queue.sv
// tb/tb_wb_queue.sv - scoreboard bench for wb_queue with a queue-based reference model
module tb_wb_queue;
    import params::*;

    localparam int DEPTH = 4;

    typedef struct {
        reg_index rd;
        word      data;
    } ent_t;

    logic                   clock = 1'b0;
    logic                   reset;
    logic                   flush;
    logic [31:0]            pending;
    logic [$clog2(DEPTH):0] count;
    logic                   empty;
    logic                   full;
`ifdef WB_BYPASS_EN
    reg_index               lookup_idx;
    logic                   lookup_hit;
    word                    lookup_data;
`endif

    wb_queue_if bus ();

    wb_queue #(.DEPTH(DEPTH)) dut (
        .clock   (clock),
        .reset   (reset),
        .bus     (bus),
        .flush   (flush),
        .pending (pending),
        .count   (count),
        .empty   (empty),
        .full    (full)
`ifdef WB_BYPASS_EN
        ,
        .lookup_idx  (lookup_idx),
        .lookup_hit  (lookup_hit),
        .lookup_data (lookup_data)
`endif
    );

    always #5 clock = ~clock;

    ent_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   writes_seen = 0;
    bit   mon_en = 1'b0;
    bit   pend_push = 1'b0;
    ent_t pend_ent;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: compares DUT outputs against the model contents, then retires the head.
    always @(negedge clock) begin
        if (mon_en) begin
            int          n;
            bit          mfull;
            logic [31:0] ep;
            bit          h;
            word         d;
            n     = exp_q.size();
            mfull = (n == DEPTH);
            check("lsu_ready", 32'(bus.lsu_ready), 32'(!mfull && !flush));
            check("alu_ready", 32'(bus.alu_ready), 32'(!mfull && !flush && !bus.lsu_valid));
            check("count", 32'(count), 32'(n));
            check("empty", 32'(empty), 32'(n == 0));
            check("full", 32'(full), 32'(mfull));
            ep = '0;
            foreach (exp_q[i]) ep[exp_q[i].rd] = 1'b1;
            ep[0] = 1'b0;
            check("pending", pending, ep);
            check("mem_op", 32'(bus.mem_op), 32'((n > 0 && !flush) ? WRITE_REG_DATA : IDLE_REG_OP));
            if (n > 0) begin
                check("rd", 32'(bus.rd), 32'(exp_q[0].rd));
                check("write_data", bus.write_data, exp_q[0].data);
            end else begin
                check("rd_idle", 32'(bus.rd), 32'd0);
                check("write_data_idle", bus.write_data, 32'd0);
            end
            h = 1'b0;
            d = '0;
`ifdef WB_BYPASS_EN
            if (lookup_idx != '0) begin
                foreach (exp_q[i]) begin
                    if (exp_q[i].rd == lookup_idx) begin
                        h = 1'b1;
                        d = exp_q[i].data;
                    end
                end
            end
            check("lookup_hit", 32'(lookup_hit), 32'(h));
            check("lookup_data", lookup_data, d);
`endif
            if (flush) begin
                exp_q.delete();
            end else if (n > 0) begin
                void'(exp_q.pop_front());
                writes_seen++;
            end
        end
    end

    // One stimulus cycle: commit last cycle's accepted result to the model, drive new inputs.
    task automatic cycle(input logic av, input reg_index ard, input word ad,
                         input logic lv, input reg_index lrd, input word ld,
                         input logic fl, input reg_index lk);
        bit mfull;
        @(posedge clock);
        #1;
        if (pend_push) exp_q.push_back(pend_ent);
        pend_push     = 1'b0;
        bus.alu_valid = av;
        bus.alu_rd    = ard;
        bus.alu_data  = ad;
        bus.lsu_valid = lv;
        bus.lsu_rd    = lrd;
        bus.lsu_data  = ld;
        flush         = fl;
`ifdef WB_BYPASS_EN
        lookup_idx    = lk;
`endif
        mfull = (exp_q.size() == DEPTH);
        if (!fl && !mfull) begin
            if (lv) begin
                pend_push = (lrd != '0);
                pend_ent  = '{rd: lrd, data: ld};
            end else if (av) begin
                pend_push = (ard != '0);
                pend_ent  = '{rd: ard, data: ad};
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
    endtask

    initial begin
        #200000;
        errors++;
        $display("FAIL watchdog timeout");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        reset         = 1'b1;
        flush         = 1'b0;
        bus.alu_valid = 1'b1;
        bus.alu_rd    = 5'd1;
        bus.alu_data  = 32'h1;
        bus.lsu_valid = 1'b1;
        bus.lsu_rd    = 5'd2;
        bus.lsu_data  = 32'h2;
`ifdef WB_BYPASS_EN
        lookup_idx    = 5'd0;
`endif
        #12;
        check("reset_lsu_ready", 32'(bus.lsu_ready), 32'd0);
        check("reset_alu_ready", 32'(bus.alu_ready), 32'd0);
        check("reset_mem_op", 32'(bus.mem_op), 32'(IDLE_REG_OP));
        check("reset_rd", 32'(bus.rd), 32'd0);
        check("reset_write_data", bus.write_data, 32'd0);
        check("reset_pending", pending, 32'd0);
        check("reset_count", 32'(count), 32'd0);
        check("reset_empty", 32'(empty), 32'd1);
        check("reset_full", 32'(full), 32'd0);
        bus.alu_valid = 1'b0;
        bus.lsu_valid = 1'b0;
        @(negedge clock);
        reset = 1'b0;
        @(posedge clock);
        #1;
        mon_en = 1'b1;

        cycle(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'd0, 1'b0, 5'd5);
        idle(2);

        cycle(1'b1, 5'd3, 32'd1, 1'b1, 5'd4, 32'd2, 1'b0, 5'd4);
        cycle(1'b1, 5'd3, 32'd1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd3);
        idle(2);

        cycle(1'b1, 5'd0, 32'h55, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
        idle(2);

        for (int i = 0; i < 4; i++) cycle(1'b1, 5'd7, 32'(10 + i), 1'b0, 5'd0, 32'd0, 1'b0, 5'd7);
        idle(2);

        cycle(1'b1, 5'd8, 32'h20, 1'b0, 5'd0, 32'd0, 1'b0, 5'd8);
        cycle(1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 32'h21, 1'b0, 5'd9);
        cycle(1'b1, 5'd10, 32'h22, 1'b0, 5'd0, 32'd0, 1'b1, 5'd9);
        idle(2);

        cycle(1'b1, 5'd9, 32'hA, 1'b0, 5'd0, 32'd0, 1'b0, 5'd9);
        cycle(1'b1, 5'd9, 32'hB, 1'b0, 5'd0, 32'd0, 1'b0, 5'd9);
        cycle(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd9);
        cycle(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
        idle(1);

        for (int i = 0; i < 400; i++) begin
            cycle(1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom,
                  1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom,
                  1'($urandom_range(0, 15) == 0), 5'($urandom_range(0, 7)));
        end
        idle(2);

        // Asynchronous reset while an entry is at the head.
        cycle(1'b1, 5'd6, 32'h77, 1'b0, 5'd0, 32'd0, 1'b0, 5'd6);
        @(posedge clock);
        #2;
        mon_en        = 1'b0;
        bus.alu_valid = 1'b0;
        check("pre_reset_mem_op", 32'(bus.mem_op), 32'(WRITE_REG_DATA));
        check("pre_reset_write_data", bus.write_data, 32'h77);
        reset = 1'b1;
        #1;
        check("async_reset_mem_op", 32'(bus.mem_op), 32'(IDLE_REG_OP));
        check("async_reset_count", 32'(count), 32'd0);
        check("async_reset_pending", pending, 32'd0);
        check("async_reset_lsu_ready", 32'(bus.lsu_ready), 32'd0);
        exp_q.delete();
        pend_push = 1'b0;
        @(negedge clock);
        reset = 1'b0;
        @(posedge clock);
        #1;
        mon_en = 1'b1;
        cycle(1'b0, 5'd0, 32'd0, 1'b1, 5'd12, 32'h1234, 1'b0, 5'd12);
        idle(3);

        check("writes_seen_nonzero", 32'(writes_seen > 100), 32'd1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
